beta_imem_arbiter: RTL
======================

// Module: beta_imem_arbiter
// PURPOSE
//  Two-port arbiter for the instruction memory req/ready/valid protocol.
//  Shares one imem port between port 0 (fetch unit) and port 1 (debug/prefetch requester).
//  Uses round-robin grant, one outstanding transaction, and a response timeout.
//  Sits between the requesters and the instruction memory (or a future AMBA converter).
// PARAMETERS
//  DataWidth      32  width of instruction data
//  AddrWidth      32  width of fetch address
//  TimeoutCycles  16  max cycles in ARB_WVLD before abort; legal range >=2
// PORTS
//  clk_i             in   1            single clock, rising edge
//  rst_i             in   1            asynchronous, active-high reset
//  arb_req_i         in   2            per-port request; held until arb_ready_o
//  arb_addr_i        in   2*AddrWidth  per-port address; [AddrWidth-1:0] = port 0
//  arb_ready_o       out  2            per-port request-accepted pulse
//  arb_valid_o       out  2            per-port response-valid pulse
//  arb_err_o         out  2            per-port timeout pulse
//  arb_rdata_o       out  DataWidth    response data, shared by both ports
//  arb_busy_o        out  1            high when the FSM is not in ARB_IDLE
//  mem_req_o         out  1            request to imem
//  mem_addr_o        out  AddrWidth    address to imem
//  mem_ready_i       in   1            imem accepted the request
//  mem_valid_i       in   1            imem response valid; 1-cycle pulse
//  mem_rdata_i       in   DataWidth    imem response data
// BEHAVIOUR
//  Reset (async, any state):
//   - state=ARB_IDLE, mem_req_o=0, mem_addr_o=0, gnt=0, last_gnt=1, timeout counter=0.
//   - All arb_*_o outputs are 0.
//  FSM states: ARB_IDLE, ARB_REQ, ARB_WVLD. Exactly one transaction is outstanding.
//  ARB_IDLE:
//   - If any arb_req_i is high: register gnt, then mem_addr_o<=arb_addr_i[gnt] and mem_req_o<=1.
//   - Go to ARB_REQ. mem_req_o rises the cycle after the request is seen (1-cycle latency).
//   - Round-robin: both ports requesting -> grant the port != last_gnt; otherwise the lone requester.
//  ARB_REQ:
//   - mem_req_o stays 1 until mem_ready_i. Requests are never cancelled.
//   - A requester dropping arb_req_i here is a protocol violation; the arbiter ignores it.
//   - arb_ready_o[gnt] = mem_ready_i (combinational, in ARB_REQ only).
//   - On mem_ready_i: mem_req_o<=0, counter<=0, go to ARB_WVLD.
//  ARB_WVLD:
//   - arb_valid_o[gnt] = mem_valid_i (combinational, in ARB_WVLD only).
//   - On mem_valid_i: last_gnt<=gnt, go to ARB_IDLE.
//   - Otherwise counter increments each cycle.
//   - Abort when counter==TimeoutCycles-1 and mem_valid_i is low:
//     register arb_err_o[gnt]=1 for exactly 1 cycle, set last_gnt<=gnt, go to ARB_IDLE.
//   - mem_valid_i on the abort cycle wins: this is a normal completion, no error.
//  arb_rdata_o = mem_rdata_i while any arb_valid_o bit is high; otherwise 0.
//  mem_ready_i or mem_valid_i seen in ARB_IDLE (stray or late) is ignored; no output toggles.
//  The idle grant cycle always happens, so back-to-back transactions have one ARB_IDLE bubble.
//  The non-granted port never sees ready, valid or err.
//  Counter width is $clog2(TimeoutCycles); it saturates and never wraps.
// TESTING
//  1. Reset, then arb_req_i=01 with addr0=0x100 at cycle 0; mem_ready_i at cycle 2;
//     mem_valid_i with rdata=0x00000013 at cycle 4.
//     -> mem_req_o=1 in cycles 1-2, mem_addr_o=0x100, arb_ready_o=01 at cycle 2,
//        arb_valid_o=01 and arb_rdata_o=0x13 at cycle 4, busy low from cycle 5.
//  2. arb_req_i=11 held continuously with addr0=0x200 and addr1=0x300.
//     -> grants in order 0,1,0,1 with matching mem_addr_o; never the same port twice in a row.
//  3. Ready given, then mem_valid_i withheld for 16 cycles.
//     -> arb_err_o[gnt] pulses once on the 16th ARB_WVLD cycle, FSM returns to ARB_IDLE.
//     -> A valid arriving afterwards produces no arb_valid_o.
//  4. rst_i asserted mid-ARB_WVLD.
//     -> mem_req_o and all arb_*_o outputs are 0 immediately, without waiting for a clock edge.
//     -> After release, arb_req_i=11 grants port 0 first.
//  5. Only port 1 requesting continuously.
//     -> port 1 is granted every transaction, one idle cycle between mem_req_o pulses,
//        and arb_ready_o[0] and arb_valid_o[0] stay 0 throughout.
//  6. mem_valid_i on the exact abort cycle.
//     -> arb_valid_o pulses and arb_err_o stays 0.

Source files
------------

// File: rtl/beta_imem_arbiter_if.sv
// Bundle of the requester-side and imem-side handshake signals of the instruction memory arbiter.
// The arbiter uses the slave view; the requesters/memory environment uses the master view.
interface beta_imem_arbiter_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
) ();
    logic [1:0]             arb_req_i;
    logic [2*AddrWidth-1:0] arb_addr_i;
    logic [1:0]             arb_ready_o;
    logic [1:0]             arb_valid_o;
    logic [1:0]             arb_err_o;
    logic [DataWidth-1:0]   arb_rdata_o;
    logic                   arb_busy_o;
    logic                   mem_req_o;
    logic [AddrWidth-1:0]   mem_addr_o;
    logic                   mem_ready_i;
    logic                   mem_valid_i;
    logic [DataWidth-1:0]   mem_rdata_i;

    modport slave (
        input  arb_req_i, arb_addr_i, mem_ready_i, mem_valid_i, mem_rdata_i,
        output arb_ready_o, arb_valid_o, arb_err_o, arb_rdata_o, arb_busy_o,
        output mem_req_o, mem_addr_o
    );

    modport master (
        output arb_req_i, arb_addr_i, mem_ready_i, mem_valid_i, mem_rdata_i,
        input  arb_ready_o, arb_valid_o, arb_err_o, arb_rdata_o, arb_busy_o,
        input  mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/beta_imem_arbiter.sv
// Round-robin arbiter sharing one instruction memory port between the fetch unit (port 0)
// and a debug/prefetch requester (port 1), one outstanding transaction, response timeout.
module beta_imem_arbiter #(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    beta_imem_arbiter_if.slave bus
);
    localparam int CntWidth = $clog2(TimeoutCycles);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WVLD = 2'd2
    } arb_state_t;

    arb_state_t           r_state, w_state_nxt;
    logic                 r_gnt, w_gnt_nxt;
    logic                 r_last_gnt, w_last_gnt_nxt;
    logic                 r_mem_req, w_mem_req_nxt;
    logic [AddrWidth-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [CntWidth-1:0]  r_cnt, w_cnt_nxt;
    logic [1:0]           r_err, w_err_nxt;
    logic [1:0]           w_ready;
    logic [1:0]           w_valid;
    logic                 w_pick;

    // Both requesting: favour the port that did not own the previous transaction.
    assign w_pick = (bus.arb_req_i == 2'b11) ? ~r_last_gnt : bus.arb_req_i[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ARB_IDLE;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_cnt      <= '0;
            r_err      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_last_gnt_nxt = r_last_gnt;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        w_cnt_nxt      = r_cnt;
        w_err_nxt      = 2'b00;
        w_ready        = 2'b00;
        w_valid        = 2'b00;
        case (r_state)
            ARB_IDLE: begin
                if (|bus.arb_req_i) begin
                    w_gnt_nxt      = w_pick;
                    w_mem_addr_nxt = w_pick ? bus.arb_addr_i[2*AddrWidth-1:AddrWidth]
                                            : bus.arb_addr_i[AddrWidth-1:0];
                    w_mem_req_nxt  = 1'b1;
                    w_state_nxt    = ARB_REQ;
                end
            end
            ARB_REQ: begin
                w_ready[r_gnt] = bus.mem_ready_i;
                if (bus.mem_ready_i) begin
                    w_mem_req_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ARB_WVLD;
                end
            end
            ARB_WVLD: begin
                // A response landing on the abort cycle still counts as a normal completion.
                w_valid[r_gnt] = bus.mem_valid_i;
                if (bus.mem_valid_i) begin
                    w_last_gnt_nxt = r_gnt;
                    w_state_nxt    = ARB_IDLE;
                end else if (r_cnt == CntLast) begin
                    w_err_nxt[r_gnt] = 1'b1;
                    w_last_gnt_nxt   = r_gnt;
                    w_state_nxt      = ARB_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CntWidth'(1);
                end
            end
            default: begin
                w_mem_req_nxt = 1'b0;
                w_state_nxt   = ARB_IDLE;
            end
        endcase
    end

    assign bus.arb_ready_o = w_ready;
    assign bus.arb_valid_o = w_valid;
    assign bus.arb_err_o   = r_err;
    assign bus.arb_rdata_o = (|w_valid) ? bus.mem_rdata_i : '0;
    assign bus.arb_busy_o  = (r_state != ARB_IDLE);
    assign bus.mem_req_o   = r_mem_req;
    assign bus.mem_addr_o  = r_mem_addr;
endmodule
